// File: rtl/n8_responder.sv
// rtl/n8_responder.sv - N8 serial pad responder: answers an external latch/pulse master with 8 button bits.
module n8_responder #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER      = 4,
    parameter int ACTIVE_LOW  = 1,
    parameter int TAIL_BIT    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       latch,
    input  logic       pulse,
    input  logic [7:0] buttons,
    output logic       data_out,
    output logic [3:0] bit_index,
    output logic       busy,
    output logic       frame_done
);

    localparam int   CW       = $clog2(FILTER + 1);
    localparam logic TAIL     = (TAIL_BIT != 0);
    localparam logic IDLE_OUT = (ACTIVE_LOW != 0);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    // Index 0 carries latch, index 1 carries pulse.
    logic [1:0]                  raw;
    logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [1:0][CW-1:0]          cnt_q, cnt_d;
    logic [1:0]                  filt_q, filt_d;
    logic [1:0]                  filt_prev_q, filt_prev_d;
    logic [1:0]                  rise_q, rise_d;
    logic                        latch_fall_q, latch_fall_d;

    state_t     state_q, state_d;
    logic [7:0] shadow_q, shadow_d;
    logic [3:0] bit_index_q, bit_index_d;
    logic       busy_q, busy_d;
    logic       frame_done_q, frame_done_d;
    logic       data_out_q, data_out_d;
    logic       out_bit;

    assign raw = {pulse, latch};

    always_comb begin
        sync_d      = sync_q;
        cnt_d       = cnt_q;
        filt_d      = filt_q;
        filt_prev_d = filt_q;
        rise_d      = filt_q & ~filt_prev_q;
        for (int i = 0; i < 2; i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], raw[i]};
            if (sync_q[i][SYNC_STAGES-1] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CW'(FILTER - 1)) begin
                filt_d[i] = sync_q[i][SYNC_STAGES-1];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
        latch_fall_d = ~filt_q[0] & filt_prev_q[0];
    end

    always_comb begin
        state_d      = state_q;
        shadow_d     = shadow_q;
        bit_index_d  = bit_index_q;
        frame_done_d = 1'b0;
        // A new latch always restarts the frame, even mid-shift; a coincident pulse is lost.
        if (rise_q[0]) begin
            state_d     = S_LOAD;
            shadow_d    = buttons;
            bit_index_d = '0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    shadow_d    = buttons;
                    bit_index_d = '0;
                    if (latch_fall_q) state_d = S_SHIFT;
                end
                S_SHIFT: begin
                    if (rise_q[1]) begin
                        shadow_d    = {TAIL, shadow_q[7:1]};
                        bit_index_d = bit_index_q + 4'd1;
                        if (bit_index_q == 4'd7) begin
                            state_d      = S_DONE;
                            frame_done_d = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
        busy_d     = (state_d == S_LOAD) || (state_d == S_SHIFT);
        out_bit    = (state_q == S_IDLE) ? 1'b0 : shadow_q[0];
        data_out_d = (ACTIVE_LOW != 0) ? ~out_bit : out_bit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            filt_q       <= '0;
            filt_prev_q  <= '0;
            rise_q       <= '0;
            latch_fall_q <= 1'b0;
            state_q      <= S_IDLE;
            shadow_q     <= '0;
            bit_index_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            data_out_q   <= IDLE_OUT;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            filt_q       <= filt_d;
            filt_prev_q  <= filt_prev_d;
            rise_q       <= rise_d;
            latch_fall_q <= latch_fall_d;
            state_q      <= state_d;
            shadow_q     <= shadow_d;
            bit_index_q  <= bit_index_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            data_out_q   <= data_out_d;
        end
    end

    assign data_out   = data_out_q;
    assign bit_index  = bit_index_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_n8_responder.sv
// tb/tb_n8_responder.sv - Self-checking bench for n8_responder acting as an emulated latch/pulse master.
module tb_n8_responder;

    localparam logic ACT_LOW = 1'b1;
    localparam logic TAIL    = 1'b1;

    logic       clk = 1'b0;
    logic       reset, latch, pulse;
    logic [7:0] buttons;
    logic       data_out;
    logic [3:0] bit_index;
    logic       busy, frame_done;

    int checks   = 0;
    int errors   = 0;
    int fd_count = 0;

    n8_responder dut (
        .clk(clk), .reset(reset), .latch(latch), .pulse(pulse), .buttons(buttons),
        .data_out(data_out), .bit_index(bit_index), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Counts high cycles, so a stuck or doubled frame_done shows up as an extra count.
    always @(negedge clk) if (frame_done === 1'b1) fd_count++;

    typedef struct {
        logic [7:0] b;
        logic [8:0] line;
    } vec_t;
    vec_t tbl[6];

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected wire level for each read: button i for reads 0..7, then the tail bit.
    function automatic logic [8:0] model_line(input logic [7:0] b);
        logic [8:0] logical;
        logic [8:0] line;
        logical = {TAIL, b};
        for (int i = 0; i < 9; i++) line[i] = ACT_LOW ? ~logical[i] : logical[i];
        return line;
    endfunction

    task automatic pulse_once(input int hi, input int lo);
        pulse = 1'b1;
        cyc(hi);
        pulse = 1'b0;
        cyc(lo);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input logic [8:0] line,
                             input int lw, input bit scramble);
        int fd0;
        int hi, lo;
        fd0     = fd_count;
        buttons = b;
        latch   = 1'b1;
        cyc(lw);
        latch = 1'b0;
        cyc(20);
        chk({tag, " busy_shift"}, busy, 1);
        chk({tag, " idx0"}, bit_index, 0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s bit%0d", tag, i), data_out, line[i]);
            if (scramble) buttons = 8'($urandom);
            hi = scramble ? $urandom_range(8, 20) : 20;
            lo = scramble ? $urandom_range(8, 20) : 20;
            pulse_once(hi, lo);
            chk($sformatf("%s idx%0d", tag, i + 1), bit_index, i + 1);
        end
        chk({tag, " tail"}, data_out, line[8]);
        chk({tag, " frame_done"}, fd_count, fd0 + 1);
        chk({tag, " busy_done"}, busy, 0);
        pulse_once(20, 20);
        chk({tag, " nowrap_idx"}, bit_index, 8);
        chk({tag, " nowrap_out"}, data_out, line[8]);
        chk({tag, " nowrap_fd"}, fd_count, fd0 + 1);
    endtask

    initial begin
        int fd0;
        logic [7:0] rb;
        tbl[0] = '{8'h11, 9'h0EE};
        tbl[1] = '{8'h00, 9'h0FF};
        tbl[2] = '{8'hFF, 9'h000};
        tbl[3] = '{8'hA5, 9'h05A};
        tbl[4] = '{8'h80, 9'h07F};
        tbl[5] = '{8'h01, 9'h0FE};

        reset = 1'b1; latch = 1'b0; pulse = 1'b0; buttons = 8'h00;
        cyc(3);
        chk("rst data_out", data_out, 1);
        chk("rst bit_index", bit_index, 0);
        chk("rst busy", busy, 0);
        chk("rst frame_done", frame_done, 0);
        reset = 1'b0;
        cyc(5);
        chk("idle data_out", data_out, 1);

        // Latency: the first edge that samples latch high is cycle 0; LOAD appears at cycle 7.
        buttons = 8'h22;
        latch   = 1'b1;
        cyc(7);
        chk("lat early busy", busy, 0);
        cyc(1);
        chk("lat busy", busy, 1);
        chk("lat idx", bit_index, 0);
        cyc(12);
        latch = 1'b0;
        cyc(20);

        // Glitch filtering during SHIFT.
        pulse_once(3, 20);
        chk("glitch3 idx", bit_index, 0);
        pulse_once(5, 20);
        chk("glitch5 idx", bit_index, 1);
        chk("glitch5 out", data_out, 0);

        // Abort after three shifts.
        fd0 = fd_count;
        pulse_once(20, 20);
        pulse_once(20, 20);
        chk("abort pre idx", bit_index, 3);
        chk("abort pre out", data_out, 1);
        buttons = 8'hFF;
        latch   = 1'b1;
        cyc(12);
        chk("abort idx", bit_index, 0);
        chk("abort busy", busy, 1);
        chk("abort out", data_out, 0);
        chk("abort fd", fd_count, fd0);
        cyc(8);
        latch = 1'b0;
        cyc(20);
        for (int i = 0; i < 8; i++) begin
            buttons = 8'($urandom);
            chk($sformatf("abort bit%0d", i), data_out, 0);
            pulse_once(20, 20);
        end
        chk("abort tail", data_out, 0);
        chk("abort fd after", fd_count, fd0 + 1);
        chk("abort idx8", bit_index, 8);

        // Latch and pulse rising together: latch wins.
        latch = 1'b1; pulse = 1'b1;
        cyc(20);
        latch = 1'b0; pulse = 1'b0;
        cyc(20);
        chk("coinc idx", bit_index, 0);
        chk("coinc busy", busy, 1);

        // Reset mid-frame, then a pulse while idle.
        buttons = 8'hFF;
        latch   = 1'b1;
        cyc(20);
        latch = 1'b0;
        cyc(20);
        pulse_once(20, 20);
        pulse_once(20, 20);
        chk("midrst pre idx", bit_index, 2);
        chk("midrst pre out", data_out, 0);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk("midrst out", data_out, 1);
        chk("midrst idx", bit_index, 0);
        chk("midrst busy", busy, 0);
        pulse_once(20, 20);
        chk("idle pulse idx", bit_index, 0);
        chk("idle pulse busy", busy, 0);
        chk("idle pulse out", data_out, 1);

        for (int t = 0; t < 6; t++)
            run_frame($sformatf("tbl%0d", t), tbl[t].b, tbl[t].line, 20, 1'b0);

        for (int r = 0; r < 20; r++) begin
            rb = 8'($urandom);
            run_frame($sformatf("rnd%0d", r), rb, model_line(rb), $urandom_range(8, 30), 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
